// File: rtl/bcd_cascade_counter_if.sv
// ----------------------------------------------------------------------------
// bcd_cascade_counter_if
//   Bundles the control inputs and count outputs of bcd_cascade_counter.
//   clk and the active-low reset stay plain module ports.
//
//   Signals
//     en        count enable, one step per clock while high
//     up_dn     1 = count up, 0 = count down
//     load      synchronous parallel load strobe (wins over en)
//     load_val  load value, digit k in bits [4k+3:4k]
//     O         current count, digit k in bits [4k+3:4k]
//     tc        combinational terminal count, for cascading to further stages
//     wrap      registered one-cycle pulse after a wrap edge
//
//   Modports
//     master    drives the controls, observes the count (bench / parent logic)
//     slave     the counter itself
// ----------------------------------------------------------------------------
interface bcd_cascade_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   O;
    logic                  tc;
    logic                  wrap;

    modport master (
        output en,
        output up_dn,
        output load,
        output load_val,
        input  O,
        input  tc,
        input  wrap
    );

    modport slave (
        input  en,
        input  up_dn,
        input  load,
        input  load_val,
        output O,
        output tc,
        output wrap
    );
endinterface

// File: rtl/bcd_cascade_counter.sv
// ----------------------------------------------------------------------------
// bcd_cascade_counter
//   Multi-digit decade counter built from DIGITS cascaded 4-bit digits, each
//   running 0..MAX_DIGIT. Supports count enable, up/down, synchronous parallel
//   load with per-digit clamping, a combinational terminal-count output for
//   chaining further stages, and a registered wrap pulse.
//
//   Parameters
//     DIGITS     number of cascaded digits (1..8), digit 0 least significant
//     MAX_DIGIT  highest value of every digit (1..9)
//
//   Ports
//     clk    rising-edge system clock
//     reset  asynchronous, active-low reset; clears the count and wrap
//     bus    slave side of bcd_cascade_counter_if (en, up_dn, load, load_val,
//            O, tc, wrap)
//
//   Per-edge priority: load > en > hold.
// ----------------------------------------------------------------------------
module bcd_cascade_counter #(
    parameter int DIGITS    = 4,
    parameter int MAX_DIGIT = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    bcd_cascade_counter_if.slave    bus
);

    localparam int              CW      = 4 * DIGITS;
    localparam logic [3:0]      MAX_D   = 4'(MAX_DIGIT);

    // ------------------------------------------------------------------------
    // Digit helpers
    // ------------------------------------------------------------------------

    // Loaded digits above the modulus are pulled down to MAX_DIGIT so the
    // register never holds an out-of-range digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        clamp_digit = (d > MAX_D) ? MAX_D : d;
    endfunction

    // The >= test also folds any unexpected value back into range.
    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        inc_digit = (d >= MAX_D) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] dec_digit(input logic [3:0] d);
        dec_digit = ((d == 4'd0) || (d > MAX_D)) ? MAX_D : d - 4'd1;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               wrap_q;
    logic               wrap_d;

    // step[k] is high when every digit below k sits at its terminal value for
    // the current direction, i.e. digit k moves on an enabled edge.
    logic [DIGITS-1:0]  step;
    logic               at_terminal;
    logic               tc;

    // ------------------------------------------------------------------------
    // Ripple enable chain and terminal detect
    // ------------------------------------------------------------------------
    always_comb begin
        logic       run;
        logic [3:0] digit;
        logic [3:0] term;

        step        = '0;
        run         = 1'b1;
        digit       = 4'd0;
        term        = bus.up_dn ? MAX_D : 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            digit   = count_q[4*k +: 4];
            step[k] = run;
            run     = run & (digit == term);
        end
        // After the last digit, run says the whole count is at the terminal.
        at_terminal = run;
    end

    // Combinational so a following stage can enable on the same edge.
    assign tc = bus.en & ~bus.load & at_terminal;

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        // tc is already low under load or when disabled, so this covers the
        // "wrap clears on load and on hold" cases too.
        wrap_d  = tc;

        if (bus.load) begin
            for (int k = 0; k < DIGITS; k++) begin
                count_d[4*k +: 4] = clamp_digit(bus.load_val[4*k +: 4]);
            end
        end else if (bus.en) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (step[k]) begin
                    count_d[4*k +: 4] = bus.up_dn ? inc_digit(count_q[4*k +: 4])
                                                  : dec_digit(count_q[4*k +: 4]);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.O    = count_q;
    assign bus.tc   = tc;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// ----------------------------------------------------------------------------
// tb_bcd_cascade_counter
//   Drives a 4-digit decade counter and a 2-digit mod-6 counter. The reference
//   model keeps each count as a plain integer in 0..(MAX_DIGIT+1)^DIGITS-1 and
//   converts to/from the digit vector arithmetically.
// ----------------------------------------------------------------------------
module tb_bcd_cascade_counter;

    logic clk;
    logic reset;

    bcd_cascade_counter_if #(.DIGITS(4)) b4 ();
    bcd_cascade_counter_if #(.DIGITS(2)) b2 ();

    bcd_cascade_counter #(.DIGITS(4), .MAX_DIGIT(9)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    bcd_cascade_counter #(.DIGITS(2), .MAX_DIGIT(5)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = 4-digit decade, index 1 = 2-digit mod-6.
    int mv    [2];
    int mw    [2];
    int radix [2];
    int ndig  [2];
    int nmod  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int r, input int d);
        logic [31:0] res;
        int          x;
        res = '0;
        x   = v;
        for (int k = 0; k < d; k++) begin
            res[4*k +: 4] = 4'(x % r);
            x = x / r;
        end
        return res;
    endfunction

    function automatic int load_to_int(input logic [31:0] lv, input int r, input int d);
        int v;
        int mul;
        int dg;
        v   = 0;
        mul = 1;
        for (int k = 0; k < d; k++) begin
            dg = int'(lv[4*k +: 4]);
            if (dg > r - 1) dg = r - 1;
            v   = v + dg * mul;
            mul = mul * r;
        end
        return v;
    endfunction

    function automatic logic [31:0] got_o(input int which);
        return (which == 0) ? 32'(b4.O) : 32'(b2.O);
    endfunction

    // One clock of stimulus on counter 'which', checking tc before the edge
    // and O / wrap after it.
    task automatic cyc(input int which, input logic e, input logic u,
                       input logic l, input logic [31:0] lv);
        logic exp_tc;
        logic term;
        if (which == 0) begin
            b4.en = e; b4.up_dn = u; b4.load = l; b4.load_val = lv[15:0];
        end else begin
            b2.en = e; b2.up_dn = u; b2.load = l; b2.load_val = lv[7:0];
        end
        #1;
        term   = u ? (mv[which] == nmod[which] - 1) : (mv[which] == 0);
        exp_tc = e && !l && term;
        chk((which == 0) ? "tc4" : "tc2",
            (which == 0) ? 32'(b4.tc) : 32'(b2.tc), 32'(exp_tc));
        @(posedge clk);
        #1;
        if (l) begin
            mv[which] = load_to_int(lv, radix[which], ndig[which]);
            mw[which] = 0;
        end else if (e) begin
            mw[which] = (term) ? 1 : 0;
            if (u) mv[which] = (mv[which] + 1) % nmod[which];
            else   mv[which] = (mv[which] + nmod[which] - 1) % nmod[which];
        end else begin
            mw[which] = 0;
        end
        chk((which == 0) ? "O4" : "O2", got_o(which),
            to_bcd(mv[which], radix[which], ndig[which]));
        chk((which == 0) ? "wrap4" : "wrap2",
            (which == 0) ? 32'(b4.wrap) : 32'(b2.wrap), 32'(mw[which]));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_O4"},    got_o(0), 32'h0);
        chk({tag, "_wrap4"}, 32'(b4.wrap), 32'h0);
        chk({tag, "_O2"},    got_o(1), 32'h0);
        chk({tag, "_wrap2"}, 32'(b2.wrap), 32'h0);
    endtask

    task automatic model_reset();
        mv[0] = 0; mw[0] = 0;
        mv[1] = 0; mw[1] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lv;
        int          pick;

        radix[0] = 10; ndig[0] = 4; nmod[0] = 10000;
        radix[1] = 6;  ndig[1] = 2; nmod[1] = 36;
        model_reset();

        reset = 1'b0;
        b4.en = 1'b0; b4.up_dn = 1'b1; b4.load = 1'b0; b4.load_val = '0;
        b2.en = 1'b0; b2.up_dn = 1'b1; b2.load = 1'b0; b2.load_val = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_cleared("por");
        chk("tc4_rst", 32'(b4.tc), 32'h0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Up carry and up wrap
        cyc(0, 1'b0, 1'b1, 1'b1, 32'h0999);
        cyc(0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("carry_0999", got_o(0), 32'h1000);
        cyc(0, 1'b0, 1'b1, 1'b1, 32'h9999);
        cyc(0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_up_O", got_o(0), 32'h0000);
        chk("wrap_up_pulse", 32'(b4.wrap), 32'h1);
        cyc(0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_up_1cyc", 32'(b4.wrap), 32'h0);

        // Down borrow and down wrap
        cyc(0, 1'b0, 1'b0, 1'b1, 32'h1000);
        cyc(0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("borrow_1000", got_o(0), 32'h0999);
        cyc(0, 1'b0, 1'b0, 1'b1, 32'h0000);
        cyc(0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_dn_O", got_o(0), 32'h9999);
        chk("wrap_dn_pulse", 32'(b4.wrap), 32'h1);

        // Load priority and clamping, with the count sitting at terminal
        cyc(0, 1'b0, 1'b1, 1'b1, 32'h9999);
        cyc(0, 1'b1, 1'b1, 1'b1, 32'h3A7F);
        chk("clamp_3A7F", got_o(0), 32'h3979);
        chk("clamp_wrap", 32'(b4.wrap), 32'h0);

        // Hold
        repeat (5) cyc(0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
        chk("hold_O", got_o(0), 32'h3979);

        // 1000 enabled edges from zero
        cyc(0, 1'b0, 1'b1, 1'b1, 32'h0);
        repeat (1000) cyc(0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("count1000", got_o(0), 32'h1000);

        // Asynchronous reset mid-count from 0x0042
        cyc(0, 1'b0, 1'b1, 1'b1, 32'h0042);
        b4.en = 1'b1; b4.up_dn = 1'b1; b4.load = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_cleared("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_cleared("rst_held");
        #3 reset = 1'b1;
        cyc(0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_first_inc", got_o(0), 32'h0001);

        // Reset right after a wrap edge must kill the pulse at once
        cyc(0, 1'b0, 1'b1, 1'b1, 32'h9999);
        cyc(0, 1'b1, 1'b1, 1'b0, 32'h0);
        b4.en = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_cleared("rst_wrap");
        #3 reset = 1'b1;

        // Randomized 4-digit traffic
        for (int i = 0; i < 2000; i++) begin
            pick = $urandom_range(0, 4);
            case (pick)
                0:       lv = 32'($urandom_range(0, 16'hFFFF));
                1:       lv = 32'h9999;
                2:       lv = 32'h0000;
                3:       lv = 32'h9998;
                default: lv = 32'h0001;
            endcase
            cyc(0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), lv);
        end

        // Mod-6, two digits: full cycle up from zero
        cyc(1, 1'b0, 1'b1, 1'b1, 32'h0);
        for (int i = 1; i <= 36; i++) begin
            cyc(1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (i == 5)  chk("m6_05", got_o(1), 32'h05);
            if (i == 6)  chk("m6_10", got_o(1), 32'h10);
            if (i == 35) chk("m6_55", got_o(1), 32'h55);
        end
        chk("m6_wrap_O", got_o(1), 32'h00);
        chk("m6_wrap_pulse", 32'(b2.wrap), 32'h1);

        // Mod-6 clamp on load
        cyc(1, 1'b1, 1'b0, 1'b1, 32'h9F);
        chk("m6_clamp", got_o(1), 32'h55);

        // Randomized mod-6 traffic
        for (int i = 0; i < 600; i++) begin
            pick = $urandom_range(0, 2);
            case (pick)
                0:       lv = 32'($urandom_range(0, 8'hFF));
                1:       lv = 32'h55;
                default: lv = 32'h00;
            endcase
            cyc(1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), lv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
